// File: rtl/projectile_pool.sv
// Pool of NUM_SLOTS rightward projectiles: edge-triggered fire with cooldown, per-frame motion,
// collision/off-screen retirement, registered pixel renderer. Optional ammo counter: PROJ_AMMO_EN.
module projectile_slot #(
  parameter int PROJ_W   = 16,
  parameter int PROJ_H   = 8,
  parameter int SPEED    = 4,
  parameter int SCREEN_W = 640
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] load_x,
  input  logic [31:0] load_y,
  input  logic        tick,
  input  logic        hit,
  input  logic [31:0] pxl_x,
  input  logic [31:0] pxl_y,
  output logic        active,
  output logic        draw
);
  logic [31:0] x, y;
  logic [32:0] step;

  assign step = {1'b0, x} + 33'(SPEED);

  // Retirement has priority over motion; load only reaches an idle slot.
  always_ff @(posedge clk) begin
    if (clr) begin
      active <= 1'b0;
      x      <= '0;
      y      <= '0;
    end else if (active) begin
      if (hit) active <= 1'b0;
      else if (tick) begin
        if (step >= 33'(SCREEN_W)) active <= 1'b0;
        else                        x      <= step[31:0];
      end
    end else if (load) begin
      active <= 1'b1;
      x      <= load_x;
      y      <= load_y;
    end
  end

  assign draw = active &&
                ({1'b0, pxl_x} >= {1'b0, x}) && ({1'b0, pxl_x} < {1'b0, x} + 33'(PROJ_W)) &&
                ({1'b0, pxl_y} >= {1'b0, y}) && ({1'b0, pxl_y} < {1'b0, y} + 33'(PROJ_H));
endmodule

module projectile_pool #(
  parameter int          NUM_SLOTS = 3,
  parameter int          PROJ_W    = 16,
  parameter int          PROJ_H    = 8,
  parameter int          SPEED     = 4,
  parameter int          SCREEN_W  = 640,
  parameter int          X_OFF     = 32,
  parameter int          Y_OFF     = 12,
  parameter int          COOLDOWN  = 8,
  parameter int          AMMO_MAX  = 5,
  parameter logic [11:0] COLOR     = 12'hFF0
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 restart,
  input  logic                 shootN,
  input  logic [31:0]          bird_x,
  input  logic [31:0]          bird_y,
  input  logic [NUM_SLOTS-1:0] collision,
  input  logic [31:0]          pxl_x,
  input  logic [31:0]          pxl_y,
  output logic [NUM_SLOTS-1:0] in_air,
  output logic [7:0]           ammo_left,
  output logic [NUM_SLOTS-1:0] drawing,
  output logic [3:0]           Red_level,
  output logic [3:0]           Green_level,
  output logic [3:0]           Blue_level
);
  localparam int CW = $clog2(COOLDOWN + 2);

  logic                 clr, shootN_d, fire_req, fire_ok, ammo_ok;
  logic [NUM_SLOTS-1:0] free, pick, load, hit;
  logic [CW-1:0]        cool_cnt;
  logic [11:0]          rgb;
  logic [31:0]          load_x, load_y;

  assign clr      = ~resetN | restart;
  assign fire_req = shootN_d & ~shootN;
  assign free     = ~in_air;
  assign pick     = free & (~free + NUM_SLOTS'(1));   // lowest idle slot, one-hot
  assign fire_ok  = fire_req & (|free) & (cool_cnt == '0) & ammo_ok;
  assign load     = fire_ok ? pick : '0;
  assign load_x   = bird_x + 32'(X_OFF);
  assign load_y   = bird_y + 32'(Y_OFF);

  always_ff @(posedge clk) begin
    if (clr) begin
      shootN_d <= 1'b1;
      cool_cnt <= '0;
    end else begin
      shootN_d <= shootN;
      if (fire_ok)                             cool_cnt <= CW'(COOLDOWN);
      else if (startOfFrame && cool_cnt != '0) cool_cnt <= cool_cnt - CW'(1);
    end
  end

`ifdef PROJ_AMMO_EN
  logic [7:0] ammo_cnt;
  assign ammo_ok   = (ammo_cnt != 8'd0);
  assign ammo_left = ammo_cnt;
  always_ff @(posedge clk) begin
    if (clr)          ammo_cnt <= 8'(AMMO_MAX);
    else if (fire_ok) ammo_cnt <= ammo_cnt - 8'd1;
  end
`else
  assign ammo_ok   = 1'b1;
  assign ammo_left = 8'(AMMO_MAX);
`endif

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    projectile_slot #(
      .PROJ_W(PROJ_W), .PROJ_H(PROJ_H), .SPEED(SPEED), .SCREEN_W(SCREEN_W)
    ) u_slot (
      .clk    (clk),
      .clr    (clr),
      .load   (load[i]),
      .load_x (load_x),
      .load_y (load_y),
      .tick   (startOfFrame),
      .hit    (collision[i]),
      .pxl_x  (pxl_x),
      .pxl_y  (pxl_y),
      .active (in_air[i]),
      .draw   (hit[i])
    );
  end

  // Single shared colour, so overlapping slots need no priority resolution.
  always_ff @(posedge clk) begin
    if (clr) begin
      drawing <= '0;
      rgb     <= '0;
    end else begin
      drawing <= hit;
      rgb     <= (|hit) ? COLOR : 12'h000;
    end
  end

  assign Red_level   = rgb[11:8];
  assign Green_level = rgb[7:4];
  assign Blue_level  = rgb[3:0];
endmodule
